instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 25 ++
 rtl/instr_fetch.sv | 92 +++++++++
 tb/tb_instr_fetch.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions: word width, fetch FSM encoding and the
// instruction-length rule used by the fetch unit.
package instr_fetch_pkg;

    localparam int WORD_W = 8;

    // Opcodes whose low nibble is at or above this value carry no operand byte.
    localparam logic [3:0] ONE_BYTE_MIN = 4'h8;

    typedef enum logic [1:0] {
        S_ISSUE,
        S_OP,
        S_OPND,
        S_PRESENT
    } fetchState_t;

    function automatic logic isOneByte(input logic [WORD_W-1:0] opcode);
        return opcode[3:0] >= ONE_BYTE_MIN;
    endfunction

    function automatic logic [WORD_W-1:0] instrLen(input logic [WORD_W-1:0] opcode);
        return isOneByte(opcode) ? WORD_W'(1) : WORD_W'(2);
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one- or two-byte instructions from an
// external synchronous ROM and presents them to the decoder with a valid/ready handshake.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 8'h00
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [WORD_W-1:0] ROM_ADDR,
    input  logic [WORD_W-1:0] ROM_DATA,
    output logic [WORD_W-1:0] INSTR_OPCODE,
    output logic [WORD_W-1:0] INSTR_OPERAND,
    output logic [WORD_W-1:0] INSTR_PC,
    output logic              INSTR_VALID,
    input  logic              INSTR_READY,
    input  logic              BRANCH_EN,
    input  logic [WORD_W-1:0] BRANCH_ADDR
);

    fetchState_t       state;
    fetchState_t       stateNext;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] fptr;
    logic [WORD_W-1:0] opcode;
    logic [WORD_W-1:0] operand;
    logic [WORD_W-1:0] instrPc;
    logic [WORD_W-1:0] nextPc;
    logic              handshake;

    assign handshake = (state == S_PRESENT) && INSTR_READY;
    assign nextPc    = pc + instrLen(opcode);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_ISSUE;
        end else begin
            state <= stateNext;
        end
    end

    // A branch overrides everything in flight, including a completing handshake.
    always_comb begin
        stateNext = state;
        if (BRANCH_EN) begin
            stateNext = S_ISSUE;
        end else begin
            unique case (state)
                S_ISSUE:   stateNext = S_OP;
                S_OP:      stateNext = isOneByte(ROM_DATA) ? S_PRESENT : S_OPND;
                S_OPND:    stateNext = S_PRESENT;
                S_PRESENT: if (handshake) stateNext = S_ISSUE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc      <= RESET_PC;
            fptr    <= RESET_PC;
            opcode  <= '0;
            operand <= '0;
            instrPc <= '0;
        end else if (BRANCH_EN) begin
            pc   <= BRANCH_ADDR;
            fptr <= BRANCH_ADDR;
        end else begin
            unique case (state)
                S_ISSUE: fptr <= pc + WORD_W'(1);
                S_OP: begin
                    opcode  <= ROM_DATA;
                    instrPc <= pc;
                    if (isOneByte(ROM_DATA)) operand <= '0;
                end
                S_OPND: operand <= ROM_DATA;
                S_PRESENT: begin
                    if (handshake) begin
                        pc   <= nextPc;
                        fptr <= nextPc;
                    end
                end
            endcase
        end
    end

    assign ROM_ADDR      = fptr;
    assign INSTR_OPCODE  = opcode;
    assign INSTR_OPERAND = operand;
    assign INSTR_PC      = instrPc;
    assign INSTR_VALID   = (state == S_PRESENT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a synchronous ROM model.
module tb_instr_fetch;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] ROM_ADDR;
    logic [7:0] romData;
    logic [7:0] INSTR_OPCODE;
    logic [7:0] INSTR_OPERAND;
    logic [7:0] INSTR_PC;
    logic       INSTR_VALID;
    logic       INSTR_READY;
    logic       BRANCH_EN;
    logic [7:0] BRANCH_ADDR;

    logic [7:0] rom [256];
    int compared   = 0;
    int mismatched = 0;
    int lat;

    always #5 CLK = ~CLK;

    always_ff @(posedge CLK) romData <= rom[ROM_ADDR];

    instr_fetch #(.RESET_PC(8'h00)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ROM_ADDR     (ROM_ADDR),
        .ROM_DATA     (romData),
        .INSTR_OPCODE (INSTR_OPCODE),
        .INSTR_OPERAND(INSTR_OPERAND),
        .INSTR_PC     (INSTR_PC),
        .INSTR_VALID  (INSTR_VALID),
        .INSTR_READY  (INSTR_READY),
        .BRANCH_EN    (BRANCH_EN),
        .BRANCH_ADDR  (BRANCH_ADDR)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Ticks until INSTR_VALID rises (bounded); returns the number of edges taken.
    task automatic waitValid(input string tag, output int n);
        n = 0;
        while (INSTR_VALID !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {7'd0, INSTR_VALID}, 8'h01);
    endtask

    task automatic checkInstr(input string tag, input logic [7:0] ePc,
                              input logic [7:0] eOp, input logic [7:0] eOpnd);
        chk({tag, "_pc"}, INSTR_PC, ePc);
        chk({tag, "_op"}, INSTR_OPCODE, eOp);
        chk({tag, "_opnd"}, INSTR_OPERAND, eOpnd);
    endtask

    task automatic accept(input string tag);
        INSTR_READY = 1'b1;
        tick();
        INSTR_READY = 1'b0;
        chk({tag, "_vld_drop"}, {7'd0, INSTR_VALID}, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
        rom[8'h00] = 8'h12; rom[8'h01] = 8'h34; rom[8'h02] = 8'h0A;
        rom[8'h03] = 8'h21; rom[8'h04] = 8'h55;
        rom[8'h05] = 8'h03; rom[8'h06] = 8'h99;
        rom[8'h80] = 8'h1C;
        rom[8'hFF] = 8'h05;
        rom[8'h40] = 8'h48;
        rom[8'h41] = 8'h6E;

        RESET = 1'b1; INSTR_READY = 1'b0; BRANCH_EN = 1'b0; BRANCH_ADDR = 8'h00;
        tick();
        tick();
        chk("rst_valid", {7'd0, INSTR_VALID}, 8'h00);
        chk("rst_op", INSTR_OPCODE, 8'h00);
        chk("rst_opnd", INSTR_OPERAND, 8'h00);
        chk("rst_pc", INSTR_PC, 8'h00);
        chk("rst_addr", ROM_ADDR, 8'h00);
        RESET = 1'b0;

        // Two-byte then one-byte instruction, with latency checks.
        waitValid("i0", lat);
        chk("i0_lat", 8'(lat), 8'd3);
        checkInstr("i0", 8'h00, 8'h12, 8'h34);
        accept("i0");
        waitValid("i1", lat);
        chk("i1_lat", 8'(lat), 8'd2);
        checkInstr("i1", 8'h02, 8'h0A, 8'h00);
        accept("i1");

        // Decoder stall: everything must hold for 10 cycles.
        waitValid("i2", lat);
        chk("i2_lat", 8'(lat), 8'd3);
        checkInstr("i2", 8'h03, 8'h21, 8'h55);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", {7'd0, INSTR_VALID}, 8'h01);
            checkInstr("hold", 8'h03, 8'h21, 8'h55);
            chk("hold_addr", ROM_ADDR, 8'h04);
        end
        accept("i2");

        // Branch while the operand byte is in flight.
        tick();
        tick();
        BRANCH_EN = 1'b1; BRANCH_ADDR = 8'h80;
        tick();
        BRANCH_EN = 1'b0;
        chk("br_valid", {7'd0, INSTR_VALID}, 8'h00);
        chk("br_addr", ROM_ADDR, 8'h80);
        waitValid("i3", lat);
        chk("i3_lat", 8'(lat), 8'd2);
        checkInstr("i3", 8'h80, 8'h1C, 8'h00);

        // Branch from the present state to 0xFF: operand wraps to address 0x00.
        rom[8'h00] = 8'h77;
        BRANCH_EN = 1'b1; BRANCH_ADDR = 8'hFF;
        tick();
        BRANCH_EN = 1'b0;
        chk("brp_valid", {7'd0, INSTR_VALID}, 8'h00);
        waitValid("i4", lat);
        chk("i4_lat", 8'(lat), 8'd3);
        checkInstr("i4", 8'hFF, 8'h05, 8'h77);
        accept("i4");
        chk("wrap_addr", ROM_ADDR, 8'h01);
        waitValid("i5", lat);
        checkInstr("i5", 8'h01, 8'h34, 8'h0A);

        // Branch and handshake on the same edge: the branch target wins.
        BRANCH_EN = 1'b1; BRANCH_ADDR = 8'h40; INSTR_READY = 1'b1;
        tick();
        BRANCH_EN = 1'b0; INSTR_READY = 1'b0;
        chk("brhs_valid", {7'd0, INSTR_VALID}, 8'h00);
        chk("brhs_addr", ROM_ADDR, 8'h40);
        waitValid("i6", lat);
        chk("i6_lat", 8'(lat), 8'd2);
        checkInstr("i6", 8'h40, 8'h48, 8'h00);
        accept("i6");

        // Reset in S_OP, with a competing branch, restarts from RESET_PC.
        tick();
        RESET = 1'b1; BRANCH_EN = 1'b1; BRANCH_ADDR = 8'h90;
        tick();
        RESET = 1'b0; BRANCH_EN = 1'b0;
        chk("mrst_valid", {7'd0, INSTR_VALID}, 8'h00);
        checkInstr("mrst", 8'h00, 8'h00, 8'h00);
        chk("mrst_addr", ROM_ADDR, 8'h00);
        waitValid("i7", lat);
        chk("i7_lat", 8'(lat), 8'd3);
        checkInstr("i7", 8'h00, 8'h77, 8'h34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
